// File: rtl/crc_pkg.sv
// Shared definitions for the CRC-8 transmit framer: default polynomial and
// initial value, FSM state encoding, and the bytewise CRC-8 update.
package crc_pkg;

  localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC_INIT_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } state_e;

  // MSB-first CRC-8 update of register c with one data byte d
  function automatic logic [7:0] crc8_next(input logic [7:0] c,
                                           input logic [7:0] d,
                                           input logic [7:0] poly);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++) begin
      if (x[7]) x = {x[6:0], 1'b0} ^ poly;
      else      x = {x[6:0], 1'b0};
    end
    return x;
  endfunction

endpackage

// File: rtl/crc_frame_tx.sv
// crc_frame_tx: forwards payload bytes unchanged and appends a CRC-8 byte
// after each frame's last byte. A single output register sits between the
// input stream and the downstream serializer path.
// Optional feature macro: CRC_TX_STATS_EN adds the o_frame_cnt frame counter.
module crc_frame_tx
  import crc_pkg::*;
#(
  parameter logic [7:0] POLY  = CRC_POLY_DEFAULT,
  parameter logic [7:0] INIT  = CRC_INIT_DEFAULT,
  parameter int         CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [7:0]       i_s_data,
  input  logic             i_s_last,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [7:0]       o_m_data,
  output logic             o_m_last
`ifdef CRC_TX_STATS_EN
  ,
  output logic [CNT_W-1:0] o_frame_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("crc_frame_tx: CNT_W must be at least 1");
  end

  state_e     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_last_q, m_last_d;

  logic slot_free;
  logic s_accept;

  // The output register can take a new byte when empty or being drained now
  assign slot_free = !m_valid_q | i_m_ready;
  assign o_s_ready = slot_free & (state_q != ST_CRC);
  assign s_accept  = i_s_valid & o_s_ready;

  // Next-state, CRC and output-register load decisions
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;

    // Byte drained with nothing new to load: register empties, data held
    if (slot_free) m_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_PAYLOAD: begin
        if (s_accept) begin
          m_valid_d = 1'b1;
          m_data_d  = i_s_data;
          m_last_d  = 1'b0;
          crc_d     = crc8_next(crc_q, i_s_data, POLY);
          state_d   = i_s_last ? ST_CRC : ST_PAYLOAD;
        end
      end
      ST_CRC: begin
        if (slot_free) begin
          m_valid_d = 1'b1;
          m_data_d  = crc_q;
          m_last_d  = 1'b1;
          crc_d     = INIT;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        crc_d   = INIT;
      end
    endcase
  end

  // State, CRC accumulator and output register; reset discards any partial frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= INIT;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign o_m_valid = m_valid_q;
  assign o_m_data  = m_data_q;
  assign o_m_last  = m_last_q;

`ifdef CRC_TX_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Count a frame once its CRC byte has been handed downstream; wraps freely
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (m_valid_q && i_m_ready && m_last_q) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  // Frame counter register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_crc_frame_tx.sv
// Self-checking bench for crc_frame_tx. Expected output streams come from a
// polynomial long-division CRC model; a monitor collects every downstream
// handshake and checks that stalled output bytes stay stable.
module tb_crc_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst_n   = 1'b0;
  logic       i_s_valid = 1'b0;
  logic       o_s_ready;
  logic [7:0] i_s_data  = 8'h00;
  logic       i_s_last  = 1'b0;
  logic       o_m_valid;
  logic       i_m_ready = 1'b1;
  logic [7:0] o_m_data;
  logic       o_m_last;
`ifdef CRC_TX_STATS_EN
  logic [3:0] o_frame_cnt;
`endif

  crc_frame_tx #(.POLY(8'h07), .INIT(8'h00), .CNT_W(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_s_valid (i_s_valid),
    .o_s_ready (o_s_ready),
    .i_s_data  (i_s_data),
    .i_s_last  (i_s_last),
    .o_m_valid (o_m_valid),
    .i_m_ready (i_m_ready),
    .o_m_data  (o_m_data),
    .o_m_last  (o_m_last)
`ifdef CRC_TX_STATS_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  bit          rand_rdy = 1'b0;
  int unsigned cyc = 0;

  logic [7:0] got_d[$];
  bit         got_l[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];

  // CRC-8 as remainder of (message * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
    logic [8:0] rem;
    rem = 9'h000;
    for (int i = 0; i < msg.size() + 1; i++) begin
      for (int b = 7; b >= 0; b--) begin
        rem = {rem[7:0], (i < msg.size()) ? msg[i][b] : 1'b0};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: always-on or random, updated just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    i_m_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: record handshakes, verify stalled bytes are held
  initial begin
    bit         stalled;
    logic [7:0] pd;
    logic       pl;
    stalled = 1'b0;
    pd = 8'h00;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (stalled && i_rst_n) begin
        checks++;
        if (o_m_valid !== 1'b1 || o_m_data !== pd || o_m_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%02h l=%b, need v=1 d=%02h l=%b",
                   o_m_valid, o_m_data, o_m_last, pd, pl);
        end
      end
      stalled = i_rst_n && o_m_valid && !i_m_ready;
      pd = o_m_data;
      pl = o_m_last;
      if (o_m_valid && i_m_ready) begin
        got_d.push_back(o_m_data);
        got_l.push_back(o_m_last);
      end
    end
  end

  task automatic clear_q();
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic add_frame_exp(input logic [7:0] p[$]);
    foreach (p[i]) begin
      exp_d.push_back(p[i]);
      exp_l.push_back(1'b0);
    end
    exp_d.push_back(ref_crc(p));
    exp_l.push_back(1'b1);
  endtask

  function automatic void make_ascii(output logic [7:0] p[$]);
    p.delete();
    for (int k = 0; k < 9; k++) p.push_back(8'h31 + 8'(k));
  endfunction

  function automatic void make_rand(output logic [7:0] p[$]);
    int n;
    p.delete();
    n = $urandom_range(1, 12);
    for (int k = 0; k < n; k++) p.push_back(8'($urandom));
  endfunction

  // Drive bytes on the input stream; returns just after the last accept
  task automatic send_bytes(input logic [7:0] p[$], input bit mark_last, input bit gaps);
    foreach (p[i]) begin
      bit acc;
      int n;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      i_s_valid = 1'b1;
      i_s_data  = p[i];
      i_s_last  = mark_last && (i == p.size() - 1);
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = o_s_ready;
        @(posedge clk);
        #1;
        n++;
      end
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0d not accepted, o_s_ready=%b need 1", i, o_s_ready);
      end
    end
  endtask

  // Wait for n collected output bytes, then a few more cycles to expose extras
  task automatic drain(input int n);
    int k;
    k = 0;
    while (got_d.size() < n && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    if (got_d.size() < n) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes, need %0d", got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", o_m_valid); end
    checks++;
    if (o_m_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h need 00", o_m_data); end
    checks++;
    if (o_m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b need 0", o_m_last); end
    checks++;
    if (o_s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", o_s_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] p[$];
    logic [7:0] fr[$];
    clear_q();
    make_ascii(p);
    add_frame_exp(p);
    checks++;
    if (exp_d[9] !== 8'hF4) begin errors++; $display("FAIL model_check: got %02h need F4", exp_d[9]); end
    send_bytes(p, 1'b1, 1'b0);
    drain(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL basic_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL basic_byte[%0d]: got %02h/last=%b need %02h/last=%b",
                 i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    fr.delete();
    foreach (got_d[i]) begin
      fr.push_back(got_d[i]);
      if (got_l[i]) begin
        checks++;
        if (ref_crc(fr) !== 8'h00) begin errors++; $display("FAIL basic_residue: got %02h need 00", ref_crc(fr)); end
        fr.delete();
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] p[$];
    clear_q();
    p.push_back(8'h01);
    add_frame_exp(p);
    send_bytes(p, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (o_s_ready !== 1'b0) begin errors++; $display("FAIL single_ready_low: got %b need 0", o_s_ready); end
    checks++;
    if (o_m_valid !== 1'b1 || o_m_data !== 8'h01 || o_m_last !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got v=%b d=%02h l=%b need v=1 d=01 l=0", o_m_valid, o_m_data, o_m_last);
    end
    @(negedge clk);
    checks++;
    if (o_s_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b need 1", o_s_ready); end
    checks++;
    if (o_m_valid !== 1'b1 || o_m_data !== 8'h07 || o_m_last !== 1'b1) begin
      errors++;
      $display("FAIL single_crc: got v=%b d=%02h l=%b need v=1 d=07 l=1", o_m_valid, o_m_data, o_m_last);
    end
    drain(exp_d.size());
    checks++;
    if (got_d.size() != 2) begin errors++; $display("FAIL single_count: got %0d need 2", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL single_byte[%0d]: got %02h/last=%b need %02h/last=%b",
                 i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] p[$];
    logic [7:0] fr[$];
    clear_q();
    rand_rdy = 1'b1;
    make_ascii(p);
    add_frame_exp(p);
    send_bytes(p, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      make_rand(p);
      add_frame_exp(p);
      send_bytes(p, 1'b1, 1'b1);
    end
    drain(exp_d.size());
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL stall_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL stall_byte[%0d]: got %02h/last=%b need %02h/last=%b",
                 i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    fr.delete();
    foreach (got_d[i]) begin
      fr.push_back(got_d[i]);
      if (got_l[i]) begin
        checks++;
        if (ref_crc(fr) !== 8'h00) begin errors++; $display("FAIL stall_residue: got %02h need 00", ref_crc(fr)); end
        fr.delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p[$];
    int unsigned t0;
    clear_q();
    make_ascii(p);
    add_frame_exp(p);
    add_frame_exp(p);
    t0 = cyc;
    send_bytes(p, 1'b1, 1'b0);
    send_bytes(p, 1'b1, 1'b0);
    checks++;
    if (cyc - t0 != 19) begin errors++; $display("FAIL b2b_cycles: got %0d need 19", cyc - t0); end
    drain(exp_d.size());
    checks++;
    if (got_d.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d need 20", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: got %02h/last=%b need %02h/last=%b",
                 i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p[$];
    logic [7:0] part[$];
    logic [7:0] fr[$];
    clear_q();
    make_ascii(p);
    for (int k = 0; k < 4; k++) begin
      part.push_back(p[k]);
      exp_d.push_back(p[k]);
      exp_l.push_back(1'b0);
    end
    send_bytes(part, 1'b0, 1'b0);
    i_rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (o_m_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b need 0", o_m_valid); end
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_frame_exp(p);
    send_bytes(p, 1'b1, 1'b0);
    drain(exp_d.size());
    checks++;
    if (got_d.size() != exp_d.size()) begin
      errors++; $display("FAIL midreset_count: got %0d need %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL midreset_byte[%0d]: got %02h/last=%b need %02h/last=%b",
                 i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    fr.delete();
    for (int i = 4; i < got_d.size(); i++) begin
      fr.push_back(got_d[i]);
      if (got_l[i]) begin
        checks++;
        if (ref_crc(fr) !== 8'h00) begin errors++; $display("FAIL midreset_residue: got %02h need 00", ref_crc(fr)); end
        fr.delete();
      end
    end
  endtask

`ifdef CRC_TX_STATS_EN
  task automatic test_stats();
    logic [7:0] p[$];
    clear_q();
    i_rst_n = 1'b0;
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    checks++;
    if (o_frame_cnt !== 4'd0) begin errors++; $display("FAIL stats_reset: got %0d need 0", o_frame_cnt); end
    for (int f = 0; f < 3; f++) begin
      make_rand(p);
      add_frame_exp(p);
      send_bytes(p, 1'b1, 1'b0);
    end
    drain(exp_d.size());
    checks++;
    if (o_frame_cnt !== 4'd3) begin errors++; $display("FAIL stats_three: got %0d need 3", o_frame_cnt); end
    for (int f = 0; f < 14; f++) begin
      make_rand(p);
      add_frame_exp(p);
      send_bytes(p, 1'b1, 1'b0);
    end
    drain(exp_d.size());
    checks++;
    if (o_frame_cnt !== 4'd1) begin errors++; $display("FAIL stats_wrap: got %0d need 1", o_frame_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef CRC_TX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
